uart_rx_sequencer: RTL and testbench

//  Control FSM for the UART receive path. Oversamples the serial line and times start, data, parity and stop bits.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_sync.sv | 26 ++
 rtl/uart_rx_sequencer.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    localparam logic UART_LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle line level.
module uart_bit_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= UART_LINE_IDLE;
            sync_q <= UART_LINE_IDLE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive control: oversampled start/data/parity/stop timing and a one-entry
// holding register presented through a valid/ready handshake.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick_i,
    input  logic                 rx_enable_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    uart_rx_state_e       state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_bad_q, parity_bad_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    logic rx_s;
    logic mid_bit;
    logic load;

    uart_bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    assign mid_bit = baud_tick_i && (tick_cnt_q == TickLast);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_bad_d = parity_bad_q;
        load         = 1'b0;
        if (baud_tick_i && (state_q inside {START, DATA, PARITY, STOP})) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (baud_tick_i && !rx_s && rx_enable_i) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (baud_tick_i && (tick_cnt_q == TickMid)) begin
                    tick_cnt_d = '0;
                    if (!rx_s) begin
                        state_d      = DATA;
                        bit_cnt_d    = '0;
                        parity_bad_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (mid_bit) begin
                    tick_cnt_d = '0;
                    // LSB arrives first, so shift in from the top
                    shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitLast) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    tick_cnt_d   = '0;
                    parity_bad_d = ((^shreg_q) ^ rx_s) != PARITY_ODD;
                    state_d      = STOP;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    tick_cnt_d = '0;
                    load       = 1'b1;
                    // a low stop bit may be a break; wait for the line to recover
                    state_d    = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (baud_tick_i && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
        if (load) begin
            // an accept this cycle frees the slot, so only an unaccepted full slot overruns
            if (valid_q && !rx_ready_i) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shreg_q;
                ferr_d  = ~rx_s;
                perr_d  = parity_bad_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            parity_bad_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_bad_q <= parity_bad_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = ferr_q;
    assign parity_err_o  = perr_q;
    assign overrun_err_o = ovr_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench: drives serial frames bit by bit and checks delivered bytes against
// a queue of expected frames plus hand-computed literal expectations.
module tb_uart_rx_sequencer;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset, baud_tick, rx_enable;
    logic rx_line, rx_ready;
    logic [7:0] rx_data;
    logic rx_valid, frame_err, parity_err, overrun_err, busy;
    logic rx_line_p, rx_ready_p;
    logic [7:0] rx_data_p;
    logic rx_valid_p, frame_err_p, parity_err_p, overrun_err_p, busy_p;

    always #5 clk = ~clk;

    uart_rx_sequencer #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .baud_tick_i(baud_tick), .rx_enable_i(rx_enable),
        .rx_i(rx_line), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .frame_err_o(frame_err), .parity_err_o(parity_err), .overrun_err_o(overrun_err),
        .busy_o(busy)
    );

    uart_rx_sequencer #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_p (
        .clk(clk), .reset(reset), .baud_tick_i(baud_tick), .rx_enable_i(rx_enable),
        .rx_i(rx_line_p), .rx_data_o(rx_data_p), .rx_valid_o(rx_valid_p),
        .rx_ready_i(rx_ready_p), .frame_err_o(frame_err_p), .parity_err_o(parity_err_p),
        .overrun_err_o(overrun_err_p), .busy_o(busy_p)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        longint     stop_cyc;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     checks = 0;
    int     failures = 0;
    int     tick_div = 1;
    int     ovr_count = 0;
    longint cycle = 0;
    logic   mon_valid_prev = 1'b0;
    logic   mon_acc_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_parity_err(input logic [7:0] d, input logic pbit,
                                            input logic odd);
        return ((($countones(d) + int'(pbit)) % 2) != 0) != odd;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_line(input bit on_p, input logic v, input int bits);
        if (on_p) rx_line_p = v;
        else rx_line = v;
        wait_cycles(bits * OS * tick_div);
    endtask

    task automatic send_frame(input bit on_p, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop, input bit push);
        frame_t f;
        hold_line(on_p, 1'b0, 1);
        for (int i = 0; i < 8; i++) hold_line(on_p, d[i], 1);
        if (has_par) hold_line(on_p, pbit, 1);
        if (push) begin
            f.data     = d;
            f.ferr     = ~stop;
            f.perr     = 1'b0;
            f.stop_cyc = (tick_div == 1) ? cycle : -1;
            exp_q.push_back(f);
        end
        hold_line(on_p, stop, 1);
        hold_line(on_p, 1'b1, 2);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_valid || busy) && n < 3000) begin
            wait_cycles(1);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, rx_valid, 0);
        check({name, "_data"}, rx_data, 0);
        check({name, "_ferr"}, frame_err, 0);
        check({name, "_perr"}, parity_err, 0);
        check({name, "_ovr"}, overrun_err, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic parity_case(input logic [7:0] d, input logic pbit, input logic lit_perr);
        int n;
        send_frame(1'b1, d, 1'b1, pbit, 1'b1, 1'b0);
        n = 0;
        while (!rx_valid_p && n < 500) begin
            wait_cycles(1);
            n++;
        end
        check("par_valid", rx_valid_p, 1);
        check("par_data", rx_data_p, d);
        check("par_ferr", frame_err_p, 0);
        check("par_perr_model", parity_err_p, exp_parity_err(d, pbit, 1'b0));
        check("par_perr_literal", parity_err_p, lit_perr);
        check("par_ovr", overrun_err_p, 0);
        rx_ready_p = 1'b1;
        wait_cycles(1);
        rx_ready_p = 1'b0;
        check("par_valid_clear", rx_valid_p, 0);
        check("par_idle", busy_p, 0);
    endtask

    task automatic reset_mid_frame(input int div);
        logic [7:0] d;
        tick_div = div;
        wait_cycles(OS * 2 * div);
        d = 8'hC3;
        hold_line(1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) hold_line(1'b0, d[i], 1);
        rx_line = d[3];
        wait_cycles(8 * div);
        check("rst_busy_before", busy, 1);
        reset = 1'b1;
        wait_cycles(2);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        hold_line(1'b0, 1'b1, 2);
        check_reset_outputs("rst_after");
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle("rst_c3");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (cnt == 0);
            cnt = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
        end
    end

    // Every newly presented byte must be the next expected frame; a held byte must not change.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_valid_prev = 1'b0;
                mon_acc_prev   = 1'b0;
            end else begin
                if (overrun_err) ovr_count++;
                if (rx_valid && (!mon_valid_prev || mon_acc_prev)) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", rx_valid, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("frame_data", rx_data, cur.data);
                        check("frame_ferr", frame_err, cur.ferr);
                        check("frame_perr", parity_err, cur.perr);
                        if (cur.stop_cyc >= 0) begin
                            check("frame_latency", cycle - cur.stop_cyc, 11);
                        end
                    end
                end else if (mon_valid_prev && !mon_acc_prev) begin
                    check("hold_valid", rx_valid, 1);
                    check("hold_data", rx_data, cur.data);
                    check("hold_ferr", frame_err, cur.ferr);
                end
                mon_valid_prev = rx_valid;
                mon_acc_prev   = rx_valid && rx_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int ovr0;
        frame_t brk;
        reset      = 1'b1;
        rx_enable  = 1'b1;
        rx_line    = 1'b1;
        rx_line_p  = 1'b1;
        rx_ready   = 1'b1;
        rx_ready_p = 1'b0;
        wait_cycles(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        wait_cycles(4);
        check_reset_outputs("post_reset");

        // 0xA5 held until ready
        rx_ready = 1'b0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1);
        check("a5_ferr", frame_err, 0);
        check("a5_perr", parity_err, 0);
        rx_ready = 1'b1;
        wait_cycles(1);
        check("a5_valid_clear", rx_valid, 0);
        wait_idle("a5");

        // short low glitch is rejected
        rx_line = 1'b0;
        wait_cycles(4);
        rx_line = 1'b1;
        wait_cycles(30);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle("glitch_3c");

        // break: one zero frame with frame error, nothing more while low
        brk.data     = 8'h00;
        brk.ferr     = 1'b1;
        brk.perr     = 1'b0;
        brk.stop_cyc = -1;
        exp_q.push_back(brk);
        hold_line(1'b0, 1'b0, 20);
        check("break_delivered", exp_q.size(), 0);
        check("break_busy_low", busy, 1);
        hold_line(1'b0, 1'b1, 2);
        check("break_recovered", busy, 0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle("break_5a");

        // overrun: second frame dropped while first still held
        rx_ready = 1'b0;
        ovr0 = ovr_count;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_pulses", ovr_count - ovr0, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        rx_ready = 1'b1;
        wait_cycles(1);
        check("ovr_valid_clear", rx_valid, 0);
        wait_idle("ovr");

        // even parity on the parity-enabled instance
        parity_case(8'h07, 1'b0, 1'b1);
        parity_case(8'h07, 1'b1, 1'b0);

        reset_mid_frame(1);
        reset_mid_frame(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
